// File: rtl/stage4_defast_sched.sv
// rtl/stage4_defast_sched.sv - stage-4 FAST de-templating sequencer and copy-dictionary owner
module stage4_defast_sched #(
    parameter int                FAST_BITS       = 344,
    parameter int                MSG_BITS        = 280,
    parameter logic [7:0]        PID_RST         = 8'h00,
    parameter logic [7:0]        MC_RST          = 8'h00,
    parameter logic [7:0]        MT_RST          = 8'h00,
    parameter logic [MSG_BITS-1:0] DEFAULT_MESSAGE = {MSG_BITS{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_count,
    input  logic [FAST_BITS-1:0] in_msg_1,
    input  logic [FAST_BITS-1:0] in_msg_2,
    input  logic [FAST_BITS-1:0] in_msg_3,
    input  logic                 dict_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MSG_BITS-1:0]  out_msg,
    output logic [1:0]           out_slot,
    output logic                 out_err,
    output logic [7:0]           field_PID1,
    output logic [7:0]           field_MC1,
    output logic [7:0]           field_MT1
);
    localparam int P = FAST_BITS - 17;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [FAST_BITS-1:0] msg1_q, msg2_q, msg3_q, cur_msg;
    logic [1:0]           idx_q, cnt_q;
    logic [7:0]           pid_q, mc_q, mt_q;
    logic                 load;

    logic [15:0]          pmap;
    logic                 legal;
    logic [7:0]           e0, e1, e2, pid_v, mc_v, mt_v;
    logic [1:0]           n;
    logic [63:0]          body;
    logic [MSG_BITS-1:0]  dec_msg;
    logic                 unused_low;

    assign load     = (state_q == RUN) && (!out_valid || out_ready);
    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid && in_count != 2'd0) state_d = RUN;
            RUN:  if (load && idx_q == cnt_q)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (idx_q)
            2'd2:    cur_msg = msg2_q;
            2'd3:    cur_msg = msg3_q;
            default: cur_msg = msg1_q;
        endcase
    end

    // Explicit bytes pack from the top of the payload; n counts those already consumed.
    always_comb begin
        pmap  = cur_msg[FAST_BITS-1 -: 16];
        legal = pmap[15] && (pmap[11:0] == 12'h000);
        e0    = cur_msg[P   -: 8];
        e1    = cur_msg[P-8 -: 8];
        e2    = cur_msg[P-16 -: 8];
        n     = 2'd0;
        pid_v = pid_q;
        mc_v  = mc_q;
        mt_v  = mt_q;
        if (!pmap[14]) begin
            pid_v = e0;
            n     = 2'd1;
        end
        if (!pmap[13]) begin
            mc_v = (n == 2'd0) ? e0 : e1;
            n    = n + 2'd1;
        end
        if (!pmap[12]) begin
            mt_v = (n == 2'd0) ? e0 : (n == 2'd1) ? e1 : e2;
            n    = n + 2'd1;
        end
        case (n)
            2'd0:    body = cur_msg[P    -: 64];
            2'd1:    body = cur_msg[P-8  -: 64];
            2'd2:    body = cur_msg[P-16 -: 64];
            default: body = cur_msg[P-24 -: 64];
        endcase
        dec_msg = legal ? {pid_v, mc_v, mt_v, 8'h00, body, {(MSG_BITS-96){1'b0}}}
                        : DEFAULT_MESSAGE;
    end

    assign unused_low = ^cur_msg[P-88:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 2'd0;
            msg1_q  <= '0;
            msg2_q  <= '0;
            msg3_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                msg1_q <= in_msg_1;
                msg2_q <= in_msg_2;
                msg3_q <= in_msg_3;
                cnt_q  <= in_count;
                idx_q  <= 2'd1;
            end else if (load && idx_q != cnt_q) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_msg   <= '0;
            out_slot  <= 2'd0;
            out_err   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_msg   <= dec_msg;
            out_slot  <= idx_q;
            out_err   <= !legal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear beats a concurrent load; the loaded message already saw the old dictionary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_q <= PID_RST;
            mc_q  <= MC_RST;
            mt_q  <= MT_RST;
        end else if (dict_clear) begin
            pid_q <= PID_RST;
            mc_q  <= MC_RST;
            mt_q  <= MT_RST;
        end else if (load && legal) begin
            pid_q <= pid_v;
            mc_q  <= mc_v;
            mt_q  <= mt_v;
        end
    end

    assign field_PID1 = pid_q;
    assign field_MC1  = mc_q;
    assign field_MT1  = mt_q;
endmodule

// File: tb/tb_stage4_defast_sched.sv
// tb/tb_stage4_defast_sched.sv - directed bench for stage4_defast_sched
module tb_stage4_defast_sched;
    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, dict_clear, out_valid, out_ready, out_err;
    logic [1:0]   in_count, out_slot;
    logic [343:0] in_msg_1, in_msg_2, in_msg_3;
    logic [279:0] out_msg;
    logic [7:0]   field_PID1, field_MC1, field_MT1;
    int           n_cmp = 0;
    int           n_fail = 0;

    stage4_defast_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .in_msg_1(in_msg_1), .in_msg_2(in_msg_2), .in_msg_3(in_msg_3), .dict_clear(dict_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg), .out_slot(out_slot),
        .out_err(out_err), .field_PID1(field_PID1), .field_MC1(field_MC1), .field_MT1(field_MT1)
    );

    always #5 clk = ~clk;

    function automatic logic [343:0] mk_fast(input logic [15:0] p, input logic [23:0] bv,
                                             input int nb, input logic [63:0] body);
        logic [327:0] pl;
        pl = {body, 264'h0};
        for (int i = nb - 1; i >= 0; i--) pl = {bv[23-8*i -: 8], pl[327:8]};
        return {p, pl};
    endfunction

    function automatic logic [279:0] exp_msg(input logic [23:0] f, input logic [63:0] body);
        return {f, 8'h00, body, 184'h0};
    endfunction

    task automatic send(input logic [1:0] cnt, input logic [343:0] m1, m2, m3);
        in_valid = 1'b1; in_count = cnt; in_msg_1 = m1; in_msg_2 = m2; in_msg_3 = m3;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL send_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_count = 2'd0; dict_clear = 1'b0; out_ready = 1'b1;
        in_msg_1 = '0; in_msg_2 = '0; in_msg_3 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_slot, out_err, in_ready} !== 5'b0_00_0_1) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00001", {out_valid, out_slot, out_err, in_ready});
        end
        n_cmp++;
        if (out_msg !== 280'h0) begin n_fail++; $display("FAIL reset_msg: got %h want 0", out_msg); end
        n_cmp++;
        if ({field_PID1, field_MC1, field_MT1} !== 24'h0) begin
            n_fail++; $display("FAIL reset_dict: got %h want 000000", {field_PID1, field_MC1, field_MT1});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [279:0] e;
        e = exp_msg(24'h000000, 64'h0123456789ABCDEF);
        out_ready = 1'b1;
        send(2'd1, mk_fast(16'hF000, 24'h0, 0, 64'h0123456789ABCDEF), '0, '0);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, out_slot, out_err} !== 4'b1_01_0) begin
            n_fail++; $display("FAIL single_ctrl: got %b want 1010", {out_valid, out_slot, out_err});
        end
        n_cmp++;
        if (out_msg !== e) begin n_fail++; $display("FAIL single_msg: got %h want %h", out_msg, e); end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", out_valid); end
    endtask

    task automatic test_three;
        logic [279:0] e [1:3];
        e[1] = exp_msg(24'h112233, 64'hA1A2A3A4A5A6A7A8);
        e[2] = exp_msg(24'h112233, 64'hB1B2B3B4B5B6B7B8);
        e[3] = exp_msg(24'h442233, 64'hC1C2C3C4C5C6C7C8);
        send(2'd3, mk_fast(16'h8000, 24'h112233, 3, 64'hA1A2A3A4A5A6A7A8),
                   mk_fast(16'hF000, 24'h0, 0, 64'hB1B2B3B4B5B6B7B8),
                   mk_fast(16'hB000, 24'h440000, 1, 64'hC1C2C3C4C5C6C7C8));
        for (int s = 1; s <= 3; s++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, out_slot, out_err} !== {1'b1, 2'(s), 1'b0}) begin
                n_fail++; $display("FAIL three_ctrl%0d: got %b", s, {out_valid, out_slot, out_err});
            end
            n_cmp++;
            if (out_msg !== e[s]) begin n_fail++; $display("FAIL three_msg%0d: got %h want %h", s, out_msg, e[s]); end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL three_end: got %b want 0", out_valid); end
        n_cmp++;
        if ({field_PID1, field_MC1, field_MT1} !== 24'h442233) begin
            n_fail++; $display("FAIL three_dict: got %h want 442233", {field_PID1, field_MC1, field_MT1});
        end
    endtask

    task automatic test_illegal;
        logic [279:0] e3;
        e3 = exp_msg(24'h442233, 64'hDEADBEEF00C0FFEE);
        send(2'd3, mk_fast(16'hF001, 24'h0, 0, 64'h1111111111111111),
                   mk_fast(16'h8001, 24'h999897, 3, 64'h2222222222222222),
                   mk_fast(16'hF000, 24'h0, 0, 64'hDEADBEEF00C0FFEE));
        for (int s = 1; s <= 2; s++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, out_slot, out_err} !== {1'b1, 2'(s), 1'b1}) begin
                n_fail++; $display("FAIL illegal_ctrl%0d: got %b", s, {out_valid, out_slot, out_err});
            end
            n_cmp++;
            if (out_msg !== 280'h0) begin n_fail++; $display("FAIL illegal_msg%0d: got %h want 0", s, out_msg); end
            n_cmp++;
            if ({field_PID1, field_MC1, field_MT1} !== 24'h442233) begin
                n_fail++; $display("FAIL illegal_dict%0d: got %h want 442233", s, {field_PID1, field_MC1, field_MT1});
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, out_slot, out_err} !== 4'b1_11_0 || out_msg !== e3) begin
            n_fail++; $display("FAIL illegal_next: got %b %h want 1110 %h", {out_valid, out_slot, out_err}, out_msg, e3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [279:0] e [1:3];
        e[1] = exp_msg(24'h010203, 64'h1000000000000001);
        e[2] = exp_msg(24'h040506, 64'h2000000000000002);
        e[3] = exp_msg(24'h070809, 64'h3000000000000003);
        out_ready = 1'b0;
        send(2'd3, mk_fast(16'h8000, 24'h010203, 3, 64'h1000000000000001),
                   mk_fast(16'h8000, 24'h040506, 3, 64'h2000000000000002),
                   mk_fast(16'h8000, 24'h070809, 3, 64'h3000000000000003));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, out_slot, in_ready} !== 4'b1_01_0 || out_msg !== e[1]) begin
                n_fail++; $display("FAIL bp_hold%0d: got %b %h", c, {out_valid, out_slot, in_ready}, out_msg);
            end
            n_cmp++;
            if ({field_PID1, field_MC1, field_MT1} !== 24'h010203) begin
                n_fail++; $display("FAIL bp_dict%0d: got %h want 010203", c, {field_PID1, field_MC1, field_MT1});
            end
        end
        out_ready = 1'b1;
        for (int s = 2; s <= 3; s++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, out_slot} !== {1'b1, 2'(s)} || out_msg !== e[s]) begin
                n_fail++; $display("FAIL bp_rel%0d: got %b %h want %h", s, {out_valid, out_slot}, out_msg, e[s]);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end: got %b want 0", out_valid); end
    endtask

    task automatic test_dict_clear;
        logic [279:0] e;
        e = exp_msg(24'hA10809, 64'h5555666677778888);
        send(2'd1, mk_fast(16'hB000, 24'hA10000, 1, 64'h5555666677778888), '0, '0);
        dict_clear = 1'b1;
        @(posedge clk); #1;
        dict_clear = 1'b0;
        n_cmp++;
        if ({out_valid, out_slot, out_err} !== 4'b1_01_0 || out_msg !== e) begin
            n_fail++; $display("FAIL clr_msg: got %b %h want %h", {out_valid, out_slot, out_err}, out_msg, e);
        end
        n_cmp++;
        if ({field_PID1, field_MC1, field_MT1} !== 24'h0) begin
            n_fail++; $display("FAIL clr_dict: got %h want 000000", {field_PID1, field_MC1, field_MT1});
        end
        @(posedge clk); #1;
        send(2'd0, mk_fast(16'h8000, 24'h777777, 3, 64'h1), '0, '0);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++; $display("FAIL zero_cnt%0d: got %b want 10", c, {in_ready, out_valid});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send(2'd3, mk_fast(16'h8000, 24'hC1C2C3, 3, 64'h1), mk_fast(16'h8000, 24'hD1D2D3, 3, 64'h2),
                   mk_fast(16'h8000, 24'hE1E2E3, 3, 64'h3));
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_slot, field_PID1} !== {1'b1, 2'd1, 8'hC1}) begin
            n_fail++; $display("FAIL rmid_pre: got %b %h", {out_valid, out_slot}, field_PID1);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_slot, out_err, in_ready} !== 5'b0_00_0_1) begin
            n_fail++; $display("FAIL rmid_async: got %b want 00001", {out_valid, out_slot, out_err, in_ready});
        end
        n_cmp++;
        if ({field_PID1, field_MC1, field_MT1} !== 24'h0) begin
            n_fail++; $display("FAIL rmid_dict: got %h want 000000", {field_PID1, field_MC1, field_MT1});
        end
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++; $display("FAIL rmid_after%0d: got %b want 01", c, {out_valid, in_ready});
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_three;
        test_illegal;
        test_backpressure;
        test_dict_clear;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
